ebpc_decoder_merge: RTL and testbench

EBPC_DECODER_MERGE -- requirements
Module: ebpc_decoder_merge

---
 rtl/ebpc_decoder_merge.sv | 123 ++++++++++++
 tb/tb_ebpc_decoder_merge.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ebpc_decoder_merge.sv
// EBPC decoder merge stage: interleaves zero words and BPC-decoded nonzero words into one
// output stream, then drains the BPC padding that completes the final partial block.
package ebpc_pkg;
    localparam int DATA_W     = 8;
    localparam int BLOCK_SIZE = 8;
endpackage

module ebpc_decoder_merge #(
    parameter int DATA_W     = ebpc_pkg::DATA_W,
    parameter int BLOCK_SIZE = ebpc_pkg::BLOCK_SIZE
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flag_i,
    input  logic              flag_last_i,
    input  logic              flag_vld_i,
    output logic              flag_rdy_o,
    input  logic [DATA_W-1:0] bpc_data_i,
    input  logic              bpc_vld_i,
    output logic              bpc_rdy_o,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o,
    output logic              vld_o,
    input  logic              rdy_i,
    output logic              idle_o,
    output logic              err_o
);

    localparam int CNT_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t             state;
    logic [CNT_W-1:0]   blk_cnt;
    logic [DATA_W-1:0]  data_q;
    logic               last_q;
    logic               vld_q;
    logic               err_q;

    logic               out_free;
    logic               flag_fire;
    logic               bpc_fire;
    logic               pad_fire;
    logic               nz_fire;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   cnt_next;

    // A nonzero flag is only accepted together with its BPC value, so both
    // ready signals wait on the other stream's valid in RUN.
    always_comb begin
        out_free   = !vld_q || rdy_i;
        flag_rdy_o = 1'b0;
        bpc_rdy_o  = 1'b0;
        if (!rst_i) begin
            if (state == RUN) begin
                flag_rdy_o = out_free && (!flag_i || bpc_vld_i);
                bpc_rdy_o  = out_free && flag_vld_i && flag_i;
            end else begin
                bpc_rdy_o  = 1'b1;
            end
        end
    end

    assign flag_fire = flag_vld_i && flag_rdy_o;
    assign bpc_fire  = bpc_vld_i && bpc_rdy_o;
    assign nz_fire   = flag_fire && flag_i;
    assign pad_fire  = (state == DRAIN) && bpc_fire;
    assign cnt_inc   = blk_cnt + CNT_W'(1);
    assign cnt_next  = flag_i ? cnt_inc : blk_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= RUN;
            blk_cnt <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= pad_fire && (bpc_data_i != '0);

            if (flag_fire) begin
                data_q <= flag_i ? bpc_data_i : '0;
                last_q <= flag_last_i;
                vld_q  <= 1'b1;
            end else if (rdy_i) begin
                vld_q  <= 1'b0;
            end

            if (nz_fire || pad_fire) begin
                blk_cnt <= cnt_inc;
            end

            // End of stream mid-block leaves padding values queued in the BPC stream.
            case (state)
                RUN: begin
                    if (flag_fire && flag_last_i && (cnt_next != '0)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pad_fire && (cnt_inc == '0)) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign data_o = data_q;
    assign last_o = last_q;
    assign vld_o  = vld_q;
    assign err_o  = err_q;
    assign idle_o = (state == RUN) && !vld_q && (blk_cnt == '0);

    property p_hold_stable;
        @(posedge clk_i) disable iff (rst_i)
        (vld_o && !rdy_i) |=> (vld_o && $stable(data_o) && $stable(last_o));
    endproperty
    assert property (p_hold_stable);

endmodule

// File: tb/tb_ebpc_decoder_merge.sv
// Bench for ebpc_decoder_merge: directed scenarios, then random streams checked against
// a stream-level reference built from the flag/padding rules.
module tb_ebpc_decoder_merge;

    localparam int DATA_W = 8;
    localparam int BS     = 8;
    localparam int LIMIT  = 20000;
    localparam int NSTREAM = 40;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              flag_i, flag_last_i, flag_vld_i, flag_rdy_o;
    logic [DATA_W-1:0] bpc_data_i;
    logic              bpc_vld_i, bpc_rdy_o;
    logic [DATA_W-1:0] data_o;
    logic              last_o, vld_o, rdy_i, idle_o, err_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0]        fq[$];
    logic [DATA_W-1:0] bq[$];
    logic [DATA_W:0]   eq[$];
    int fi = 0;
    int bi = 0;
    int exp_err = 0;
    int err_seen = 0;

    ebpc_decoder_merge #(.DATA_W(DATA_W), .BLOCK_SIZE(BS)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .flag_i(flag_i), .flag_last_i(flag_last_i),
        .flag_vld_i(flag_vld_i), .flag_rdy_o(flag_rdy_o),
        .bpc_data_i(bpc_data_i), .bpc_vld_i(bpc_vld_i), .bpc_rdy_o(bpc_rdy_o),
        .data_o(data_o), .last_o(last_o), .vld_o(vld_o), .rdy_i(rdy_i),
        .idle_o(idle_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fv, input logic f, input logic fl,
                         input logic bv, input logic [DATA_W-1:0] bd);
        flag_vld_i  = fv;
        flag_i      = f;
        flag_last_i = fl;
        bpc_vld_i   = bv;
        bpc_data_i  = bd;
        #1;
    endtask

    function automatic logic [31:0] word(input logic l, input logic [DATA_W-1:0] d);
        return {23'd0, l, d};
    endfunction

    initial begin
        int outs, errs;
        bit ok;
        logic [DATA_W-1:0] v;

        // Reset with a flag pending: nothing may be accepted.
        rst_i = 1'b1;
        rdy_i = 1'b1;
        drive(1, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst_flag_rdy", 32'(flag_rdy_o), 0);
        chk("rst_bpc_rdy", 32'(bpc_rdy_o), 0);
        chk("rst_vld", 32'(vld_o), 0);
        chk("rst_idle", 32'(idle_o), 1);
        chk("rst_out", word(last_o, data_o), 0);
        chk("rst_err", 32'(err_o), 0);
        drive(0, 0, 0, 0, 0);
        rst_i = 1'b0;
        tick();

        // Flags 0,1,1,0(last), values A5,3C then six padding zeros.
        drive(1, 0, 0, 1, 8'hA5);
        chk("zero_flag_rdy", 32'(flag_rdy_o), 1);
        chk("zero_bpc_rdy", 32'(bpc_rdy_o), 0);
        tick();
        chk("s1_out0", word(last_o, data_o), word(0, 8'h00));
        drive(1, 1, 0, 1, 8'hA5);
        tick();
        chk("s1_out1", word(last_o, data_o), word(0, 8'hA5));
        drive(1, 1, 0, 1, 8'h3C);
        tick();
        chk("s1_out2", word(last_o, data_o), word(0, 8'h3C));
        drive(1, 0, 1, 1, 8'h00);
        tick();
        chk("s1_out3", word(last_o, data_o), word(1, 8'h00));
        chk("s1_out3_vld", 32'(vld_o), 1);
        drive(0, 0, 0, 1, 8'h00);
        chk("drain_flag_rdy", 32'(flag_rdy_o), 0);
        chk("drain_bpc_rdy", 32'(bpc_rdy_o), 1);
        outs = 0;
        errs = 0;
        repeat (6) begin
            tick();
            if (vld_o) outs++;
            if (err_o) errs++;
        end
        chk("drain_outs", 32'(outs), 0);
        chk("drain_errs", 32'(errs), 0);
        drive(0, 0, 0, 0, 0);
        chk("s1_idle", 32'(idle_o), 1);
        chk("s1_run_bpc_rdy", 32'(bpc_rdy_o), 0);

        // Full block of eight nonzero words: no drain.
        for (int i = 1; i <= 8; i++) begin
            drive(1, 1, (i == 8), 1, DATA_W'(i));
            tick();
            chk("s2_out", word(last_o, data_o), word((i == 8), DATA_W'(i)));
        end
        drive(1, 0, 1, 0, 0);
        chk("s2_next_accept", 32'(flag_rdy_o), 1);
        tick();
        chk("s2_next_out", word(last_o, data_o), word(1, 8'h00));
        drive(0, 0, 0, 0, 0);
        tick();
        chk("s2_idle", 32'(idle_o), 1);

        // Output back-pressure for three cycles.
        drive(1, 1, 0, 1, 8'h5A);
        tick();
        rdy_i = 1'b0;
        drive(1, 1, 1, 1, 8'h11);
        ok = 1;
        repeat (3) begin
            if (flag_rdy_o || bpc_rdy_o || !vld_o || last_o || data_o != 8'h5A) ok = 0;
            tick();
        end
        chk("stall_hold", 32'(ok), 1);
        chk("stall_data", word(last_o, data_o), word(0, 8'h5A));
        rdy_i = 1'b1;
        #1;
        chk("stall_resume", 32'(flag_rdy_o), 1);
        tick();
        chk("stall_next_out", word(last_o, data_o), word(1, 8'h11));

        // Nonzero padding value in drain (blk_cnt at 2).
        drive(0, 0, 0, 1, 8'h01);
        tick();
        chk("pad_err_pulse", 32'(err_o), 1);
        chk("pad_no_out", 32'(vld_o), 0);
        drive(0, 0, 0, 1, 8'h00);
        tick();
        chk("pad_err_once", 32'(err_o), 0);
        repeat (3) tick();
        chk("pad_still_drain", 32'(idle_o), 0);
        tick();
        drive(0, 0, 0, 0, 0);
        chk("pad_exit_idle", 32'(idle_o), 1);

        // Nonzero flag waiting on its BPC value.
        drive(1, 1, 1, 0, 8'h00);
        ok = 1;
        repeat (4) begin
            if (flag_rdy_o || vld_o) ok = 0;
            tick();
        end
        chk("bpc_wait_stall", 32'(ok), 1);
        drive(1, 1, 1, 1, 8'h77);
        chk("pair_flag_rdy", 32'(flag_rdy_o), 1);
        chk("pair_bpc_rdy", 32'(bpc_rdy_o), 1);
        tick();
        chk("pair_out", word(last_o, data_o), word(1, 8'h77));
        chk("pair_vld", 32'(vld_o), 1);

        // Reset mid-drain at blk_cnt 3.
        drive(0, 0, 0, 1, 8'h00);
        tick();
        tick();
        chk("pre_rst_idle", 32'(idle_o), 0);
        rst_i = 1'b1;
        #1;
        chk("rst_mid_bpc_rdy", 32'(bpc_rdy_o), 0);
        tick();
        rst_i = 1'b0;
        drive(0, 0, 0, 1, 8'h00);
        chk("rst_mid_vld", 32'(vld_o), 0);
        chk("rst_mid_idle", 32'(idle_o), 1);
        chk("rst_mid_run", 32'(bpc_rdy_o), 0);
        drive(0, 0, 0, 0, 0);
        tick();

        // Random streams: expected words and padding from the stream rules.
        for (int s = 0; s < NSTREAM; s++) begin
            int len, n, pad;
            bit f;
            len = $urandom_range(1, 20);
            n = 0;
            for (int k = 0; k < len; k++) begin
                f = ($urandom_range(0, 9) < 6);
                fq.push_back({f, (k == len - 1)});
                if (f) begin
                    v = DATA_W'($urandom_range(0, 255));
                    bq.push_back(v);
                    eq.push_back({(k == len - 1), v});
                    n++;
                end else begin
                    eq.push_back({(k == len - 1), {DATA_W{1'b0}}});
                end
            end
            pad = (BS - (n % BS)) % BS;
            for (int p = 0; p < pad; p++) begin
                v = ($urandom_range(0, 4) == 0) ? DATA_W'($urandom_range(1, 255)) : '0;
                if (v != 0) exp_err++;
                bq.push_back(v);
            end
        end

        rdy_i = 1'b1;
        fork
            begin
                bit fgo;
                int c;
                c = 0;
                while (fi < fq.size() && c < LIMIT) begin
                    if (!flag_vld_i && $urandom_range(0, 3) != 0) begin
                        {flag_i, flag_last_i} = fq[fi];
                        flag_vld_i = 1'b1;
                    end
                    @(negedge clk);
                    fgo = flag_vld_i && flag_rdy_o;
                    @(posedge clk);
                    #1;
                    if (fgo) begin
                        fi++;
                        flag_vld_i = 1'b0;
                    end
                    c++;
                end
                flag_vld_i = 1'b0;
            end
            begin
                bit bgo;
                int c;
                c = 0;
                while (bi < bq.size() && c < LIMIT) begin
                    if (!bpc_vld_i && $urandom_range(0, 3) != 0) begin
                        bpc_data_i = bq[bi];
                        bpc_vld_i = 1'b1;
                    end
                    @(negedge clk);
                    bgo = bpc_vld_i && bpc_rdy_o;
                    @(posedge clk);
                    #1;
                    if (bgo) begin
                        bi++;
                        bpc_vld_i = 1'b0;
                    end
                    c++;
                end
                bpc_vld_i = 1'b0;
            end
            begin
                int c;
                c = 0;
                while ((eq.size() > 0 || bi < bq.size()) && c < LIMIT) begin
                    @(negedge clk);
                    if (vld_o && rdy_i) begin
                        if (eq.size() > 0) chk("rand_out", word(last_o, data_o), 32'(eq.pop_front()));
                        else chk("rand_extra_out", 32'(vld_o), 0);
                    end
                    if (err_o) err_seen++;
                    @(posedge clk);
                    #1;
                    rdy_i = ($urandom_range(0, 3) != 0);
                    c++;
                end
                rdy_i = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    if (err_o) err_seen++;
                end
            end
        join

        chk("rand_remaining", 32'(eq.size() + (bq.size() - bi)), 0);
        chk("rand_flags_used", 32'(fi), 32'(fq.size()));
        chk("rand_err_count", 32'(err_seen), 32'(exp_err));
        chk("rand_trail_vld", 32'(vld_o), 0);
        chk("rand_idle", 32'(idle_o), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
